// File: rtl/reaction_pkg.sv
// Shared encodings and constants for the multi-player reaction timer.
// Also holds the per-digit rollover limits of the mm:ss.hh cascade.
package reaction_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_ARMED   = ST_ARMED,
        S_RUN     = ST_RUN,
        S_DONE    = ST_DONE,
        S_FAULT   = ST_FAULT,
        S_TIMEOUT = ST_TIMEOUT
    } state_t;

    localparam logic [5:0]  BLANK_ALL = 6'h3F;
    localparam logic [23:0] SAT_TIME  = 24'h595999;
    // Feedback taps 16, 14, 13, 11 -> register bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Digit order from LSB: h, t, s1, s10, m1, m10; the tens of seconds and minutes stop at 5.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Six-digit mm:ss.hh BCD counter with synchronous clear and optional
// saturation at 59:59.99.
module bcd_time_counter
    import reaction_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        clr,
    input  logic        inc,
    input  logic        sat_en,
    output logic [23:0] time_bcd,
    output logic        at_max
);

    logic [23:0] time_q;
    logic [23:0] time_nxt;
    logic        carry;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        time_nxt = time_q;
        carry    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (time_q[i*4 +: 4] == digit_max(i)) begin
                    time_nxt[i*4 +: 4] = 4'd0;
                end else begin
                    time_nxt[i*4 +: 4] = time_q[i*4 +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
    end

    assign at_max = (time_q == SAT_TIME);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            time_q <= '0;
        end else if (clr) begin
            time_q <= '0;
        end else if (inc && !(at_max && sat_en)) begin
            time_q <= time_nxt;
        end
    end

    assign time_bcd = time_q;

endmodule

// File: rtl/reaction_timer_multi.sv
// N-player reaction timer: random arming delay from an LFSR, BCD run timer,
// false-start and timeout detection, and a best-time record.
module reaction_timer_multi
    import reaction_pkg::*;
#(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          TICK_HZ    = 100,
    parameter int          N_PLAYERS  = 2,
    parameter int          MIN_WAIT_T = 100,
    parameter int          MAX_WAIT_T = 1000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic                 START_N,
    input  logic [N_PLAYERS-1:0] STOP_N,
    output logic [23:0]          TIME_BCD,
    output logic [5:0]           BLANK,
    output logic [2:0]           STATE,
    output logic [2:0]           WINNER,
    output logic                 FALSE_START,
    output logic [23:0]          BEST_BCD,
    output logic                 BEST_VALID
);

    localparam int          DIV     = CLK_HZ / TICK_HZ;
    localparam int          PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int          WAIT_W  = $clog2(MAX_WAIT_T + 1);
    localparam logic [31:0] MIN_W   = MIN_WAIT_T;
    localparam logic [31:0] RANGE_W = MAX_WAIT_T - MIN_WAIT_T + 1;

    state_t               state, state_nxt;
    logic                 start_s1, start_s2, start_d;
    logic [N_PLAYERS-1:0] stop_s1, stop_s2, stop_d;
    logic                 start_fall, stop_any;
    logic [N_PLAYERS-1:0] stop_fall;
    logic [2:0]           win_idx;
    logic [15:0]          lfsr;
    logic [PRESC_W-1:0]   presc;
    logic                 tick;
    logic [WAIT_W-1:0]    wait_ticks, tick_cnt;
    logic                 arm, cnt_inc, win_load, best_load, at_max;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        // NOTE: synchroniser flops reset to the pressed level so a key held through reset never produces an edge.
        if (RESET) begin
            {start_s1, start_s2, start_d} <= '0;
            stop_s1 <= '0;
            stop_s2 <= '0;
            stop_d  <= '0;
        end else begin
            start_s1 <= START_N;
            start_s2 <= start_s1;
            start_d  <= start_s2;
            stop_s1  <= STOP_N;
            stop_s2  <= stop_s1;
            stop_d   <= stop_s2;
        end
    end

    assign start_fall = start_d & ~start_s2;
    assign stop_fall  = stop_d & ~stop_s2;
    assign stop_any   = |stop_fall;

    always_comb begin
        win_idx = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (stop_fall[i]) win_idx = 3'(i);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    // Prescaler restarts from zero on every state change, so each state sees full ticks.
    assign tick = (presc == PRESC_W'(DIV - 1));

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            presc <= '0;
        end else if ((state == S_ARMED || state == S_RUN) && state_nxt == state) begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
        end else begin
            presc <= '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_FAULT, S_TIMEOUT: begin
                if (start_fall) begin
                    state_nxt = S_ARMED;
                    arm       = 1'b1;
                end
            end
            S_ARMED: begin
                if (stop_any)                                         state_nxt = S_FAULT;
                else if (tick && (tick_cnt + WAIT_W'(1)) == wait_ticks) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (stop_any) begin
                    state_nxt = S_DONE;
                end else if (tick) begin
                    if (at_max) state_nxt = S_TIMEOUT;
                    else        cnt_inc   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign win_load  = stop_any && (state == S_ARMED || state == S_RUN);
    assign best_load = stop_any && (state == S_RUN) && (!BEST_VALID || TIME_BCD < BEST_BCD);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            wait_ticks <= '0;
            tick_cnt   <= '0;
            WINNER     <= '0;
            BEST_BCD   <= '0;
            BEST_VALID <= 1'b0;
        end else begin
            if (arm) begin
                wait_ticks <= WAIT_W'(MIN_W + ({16'd0, lfsr} % RANGE_W));
                tick_cnt   <= '0;
            end else if (state == S_ARMED && tick) begin
                tick_cnt <= tick_cnt + WAIT_W'(1);
            end
            if (arm)           WINNER <= '0;
            else if (win_load) WINNER <= win_idx;
            if (best_load) begin
                BEST_BCD   <= TIME_BCD;
                BEST_VALID <= 1'b1;
            end
        end
    end

    bcd_time_counter u_time (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .clr      (arm),
        .inc      (cnt_inc),
        .sat_en   (1'b1),
        .time_bcd (TIME_BCD),
        .at_max   (at_max)
    );

    assign STATE       = state;
    assign BLANK       = (state == S_ARMED || state == S_FAULT) ? BLANK_ALL : 6'h00;
    assign FALSE_START = (state == S_FAULT);

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Self-checking bench for reaction_timer_multi: table of game rounds plus
// hand-written timeout and reset sequences, checked through a scoreboard.
module tb_reaction_timer_multi;
    import reaction_pkg::*;

    localparam int          CLK_HZ     = 1000;
    localparam int          TICK_HZ    = 100;
    localparam int          N_PLAYERS  = 2;
    localparam int          MIN_WAIT_T = 100;
    localparam int          MAX_WAIT_T = 400;
    localparam logic [15:0] SEED       = 16'hACE1;
    localparam int          DIV        = CLK_HZ / TICK_HZ;
    localparam int          RANGE      = MAX_WAIT_T - MIN_WAIT_T + 1;

    logic                 CLOCK_50 = 1'b0;
    logic                 RESET;
    logic                 START_N;
    logic [N_PLAYERS-1:0] STOP_N;
    logic [23:0]          TIME_BCD;
    logic [5:0]           BLANK;
    logic [2:0]           STATE;
    logic [2:0]           WINNER;
    logic                 FALSE_START;
    logic [23:0]          BEST_BCD;
    logic                 BEST_VALID;

    reaction_timer_multi #(
        .CLK_HZ     (CLK_HZ),
        .TICK_HZ    (TICK_HZ),
        .N_PLAYERS  (N_PLAYERS),
        .MIN_WAIT_T (MIN_WAIT_T),
        .MAX_WAIT_T (MAX_WAIT_T),
        .LFSR_SEED  (SEED)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .START_N     (START_N),
        .STOP_N      (STOP_N),
        .TIME_BCD    (TIME_BCD),
        .BLANK       (BLANK),
        .STATE       (STATE),
        .WINNER      (WINNER),
        .FALSE_START (FALSE_START),
        .BEST_BCD    (BEST_BCD),
        .BEST_VALID  (BEST_VALID)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference LFSR built straight from x^16+x^14+x^13+x^11+1.
    logic [15:0] m_lfsr;
    always @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) m_lfsr <= SEED;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    typedef struct {
        logic [2:0]  state;
        logic [2:0]  winner;
        logic [23:0] time_bcd;
        logic [23:0] best;
        logic        best_valid;
        logic [5:0]  blank;
    } exp_t;

    typedef struct {
        logic [N_PLAYERS-1:0] stop_n;
        int                   k;      // ticks into RUN at which STOP is seen; -1 = during ARMED
        exp_t                 exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic wait_leave(input logic [2:0] from, input int budget, input string name);
        int n = 0;
        while (STATE == from && n < budget) begin
            wait_cycles(1);
            n++;
        end
        check(name, 32'(STATE != from), 32'd1);
    endtask

    task automatic sb_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_state"},  32'(STATE),      32'(e.state));
            check({tag, "_winner"}, 32'(WINNER),     32'(e.winner));
            check({tag, "_time"},   32'(TIME_BCD),   32'(e.time_bcd));
            check({tag, "_best"},   32'(BEST_BCD),   32'(e.best));
            check({tag, "_bvalid"}, 32'(BEST_VALID), 32'(e.best_valid));
            check({tag, "_blank"},  32'(BLANK),      32'(e.blank));
            check({tag, "_fs"},     32'(FALSE_START), 32'(e.state == ST_FAULT));
        end
    endtask

    // Press START from a negedge; returns the wait the DUT should have latched.
    task automatic press_start(input string tag, output int w);
        logic [15:0] l;
        START_N = 1'b0;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        l = m_lfsr;
        w = MIN_WAIT_T + (int'(l) % RANGE);
        wait_cycles(1);
        check({tag, "_armed"},  32'(STATE),    32'(ST_ARMED));
        check({tag, "_ablank"}, 32'(BLANK),    32'(BLANK_ALL));
        check({tag, "_aclr"},   32'(TIME_BCD), 32'd0);
        check({tag, "_awin"},   32'(WINNER),   32'd0);
        START_N = 1'b1;
    endtask

    task automatic wait_run(input string tag, input int w);
        wait_cycles(w * DIV - 1);
        check({tag, "_prerun"}, 32'(STATE), 32'(ST_ARMED));
        wait_cycles(1);
        check({tag, "_run"},    32'(STATE), 32'(ST_RUN));
        check({tag, "_rblank"}, 32'(BLANK), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   w;
        exp_t e;
        string tag;

        vecs[0] = '{stop_n: 2'b01, k: 37,  exp: '{ST_DONE,  3'd1, 24'h000037, 24'h000037, 1'b1, 6'h00}};
        vecs[1] = '{stop_n: 2'b10, k: -1,  exp: '{ST_FAULT, 3'd0, 24'h000000, 24'h000037, 1'b1, 6'h3F}};
        vecs[2] = '{stop_n: 2'b00, k: 20,  exp: '{ST_DONE,  3'd0, 24'h000020, 24'h000020, 1'b1, 6'h00}};
        vecs[3] = '{stop_n: 2'b01, k: 45,  exp: '{ST_DONE,  3'd1, 24'h000045, 24'h000020, 1'b1, 6'h00}};
        vecs[4] = '{stop_n: 2'b10, k: 123, exp: '{ST_DONE,  3'd0, 24'h000123, 24'h000020, 1'b1, 6'h00}};

        RESET   = 1'b1;
        START_N = 1'b1;
        STOP_N  = '1;
        wait_cycles(3);
        check("rst_state", 32'(STATE),       32'(ST_IDLE));
        check("rst_time",  32'(TIME_BCD),    32'd0);
        check("rst_blank", 32'(BLANK),       32'd0);
        check("rst_best",  32'(BEST_VALID),  32'd0);
        RESET = 1'b0;
        wait_cycles(3);

        // STOP in IDLE does nothing.
        STOP_N = 2'b10;
        wait_cycles(6);
        check("idle_stop_state", 32'(STATE),  32'(ST_IDLE));
        check("idle_stop_win",   32'(WINNER), 32'd0);
        STOP_N = '1;
        wait_cycles(3);

        for (int i = 0; i < 5; i++) begin
            tag = $sformatf("vec%0d", i);
            press_start(tag, w);
            if (vecs[i].k < 0) begin
                wait_cycles(5);
                STOP_N = vecs[i].stop_n;
                sb.push_back(vecs[i].exp);
                wait_leave(ST_ARMED, 10, {tag, "_leave"});
            end else begin
                wait_run(tag, w);
                wait_cycles(DIV * vecs[i].k + 2);
                STOP_N = vecs[i].stop_n;
                sb.push_back(vecs[i].exp);
                wait_leave(ST_RUN, 10, {tag, "_leave"});
            end
            sb_compare(tag);
            STOP_N = '1;
            wait_cycles(4);
        end

        // Timeout: jump the counter near the top and let two ticks elapse.
        press_start("tmo", w);
        wait_run("tmo", w);
        force dut.u_time.time_q = 24'h595998;
        wait_cycles(1);
        release dut.u_time.time_q;
        check("tmo_forced", 32'(TIME_BCD), 32'h595998);
        e = '{ST_TIMEOUT, 3'd0, 24'h595999, 24'h000020, 1'b1, 6'h00};
        sb.push_back(e);
        wait_leave(ST_RUN, 30, "tmo_leave");
        sb_compare("tmo");
        STOP_N = 2'b10;
        wait_cycles(30);
        check("tmo_nowrap", 32'(TIME_BCD), 32'h595999);
        check("tmo_stay",   32'(STATE),    32'(ST_TIMEOUT));
        check("tmo_nowin",  32'(WINNER),   32'd0);
        STOP_N = '1;
        wait_cycles(4);

        // Reset in the middle of RUN with player 0 holding STOP across it.
        press_start("rst", w);
        wait_run("rst", w);
        wait_cycles(25);
        RESET  = 1'b1;
        STOP_N = 2'b10;
        wait_cycles(1);
        check("mid_rst_state",  32'(STATE),       32'(ST_IDLE));
        check("mid_rst_time",   32'(TIME_BCD),    32'd0);
        check("mid_rst_winner", 32'(WINNER),      32'd0);
        check("mid_rst_best",   32'(BEST_BCD),    32'd0);
        check("mid_rst_bvalid", 32'(BEST_VALID),  32'd0);
        check("mid_rst_fs",     32'(FALSE_START), 32'd0);
        RESET = 1'b0;
        wait_cycles(3);
        press_start("held", w);
        wait_cycles(20);
        check("held_state", 32'(STATE),       32'(ST_ARMED));
        check("held_fs",    32'(FALSE_START), 32'd0);
        STOP_N = '1;
        wait_cycles(4);
        STOP_N = 2'b01;
        wait_leave(ST_ARMED, 10, "fresh_leave");
        check("fresh_fault",  32'(STATE),  32'(ST_FAULT));
        check("fresh_winner", 32'(WINNER), 32'd1);
        STOP_N = '1;
        wait_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
